// File: rtl/mul_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_exec_unit
// Description : Multi-cycle integer multiply execution unit (MUL, MULH,
//               MULHSU, MULHU). Accepts one instruction from the multiply
//               issue queue, computes the 2*XLEN product over LATENCY cycles,
//               then holds tag+result on the CDB until the arbiter grants it.
//               Optional feature macro: MUL_ZERO_SKIP_EN (a zero operand
//               completes one cycle after accept with result 0).
// Revision    : 1.0 - initial release
// ============================================================================
module mul_exec_unit #(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 6,
    parameter int LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [XLEN-1:0]  iss_rs1_data,
    input  logic [XLEN-1:0]  iss_rs2_data,
    input  logic [TAG_W-1:0] iss_rd_tag,
    input  logic [1:0]       iss_funct,
    output logic             ex_done,
    output logic             cdb_req,
    input  logic             cdb_grant,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [XLEN-1:0]  cdb_data,
    output logic             cdb_data_valid
);

    localparam logic [1:0] c_MUL    = 2'b00;
    localparam logic [1:0] c_MULH   = 2'b01;
    localparam logic [1:0] c_MULHSU = 2'b10;
    localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [XLEN-1:0]  op_a_q;
    logic [XLEN-1:0]  op_b_q;
    logic [1:0]       funct_q;
    logic [TAG_W-1:0] op_tag_q;   // tag of the in-flight operation
    logic [TAG_W-1:0] res_tag_q;  // tag currently presented on the CDB
    logic [XLEN-1:0]  res_q;

    logic             w_accept;
    logic             w_zero_skip;
    logic [XLEN-1:0]  w_res_now;     // product of the operands being accepted
    logic [XLEN-1:0]  w_res_latched; // product of the latched in-flight operands

    // Extend both operands to 2*XLEN according to their signedness; the
    // truncated 2*XLEN product is then exact for every funct encoding.
    function automatic logic [XLEN-1:0] mul_result(
        input logic [1:0]      funct,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [2*XLEN-1:0] ext_a;
        logic [2*XLEN-1:0] ext_b;
        logic [2*XLEN-1:0] prod;
        ext_a = {{XLEN{((funct == c_MULH) || (funct == c_MULHSU)) & a[XLEN-1]}}, a};
        ext_b = {{XLEN{(funct == c_MULH) & b[XLEN-1]}}, b};
        prod  = ext_a * ext_b;
        return (funct == c_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    endfunction

    assign w_res_now     = mul_result(iss_funct, iss_rs1_data, iss_rs2_data);
    assign w_res_latched = mul_result(funct_q, op_a_q, op_b_q);

    // Accept strobe: free in IDLE, or in DONE when the pending result leaves this cycle
    assign ex_done  = (state_q == S_IDLE) || ((state_q == S_DONE) && cdb_grant);
    assign w_accept = issue_valid && ex_done;

`ifdef MUL_ZERO_SKIP_EN
    // A zero operand makes every funct result zero, so no need to iterate
    assign w_zero_skip = (iss_rs1_data == '0) || (iss_rs2_data == '0);
`else
    assign w_zero_skip = 1'b0;
`endif

    assign cdb_req        = (state_q == S_DONE);
    assign cdb_data_valid = cdb_req && cdb_grant;
    assign cdb_tag        = res_tag_q;
    assign cdb_data       = res_q;

    // Control FSM plus operand/result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            funct_q   <= '0;
            op_tag_q  <= '0;
            res_tag_q <= '0;
            res_q     <= '0;
        end else if (w_accept) begin
            // Accepting in DONE: the old result is on the CDB this cycle,
            // so the result registers are free to take the new operation.
            op_a_q   <= iss_rs1_data;
            op_b_q   <= iss_rs2_data;
            funct_q  <= iss_funct;
            op_tag_q <= iss_rd_tag;
            cnt_q    <= c_CNT_INIT;
            if (w_zero_skip) begin
                state_q   <= S_DONE;
                res_q     <= '0;
                res_tag_q <= iss_rd_tag;
            end else if (LATENCY == 1) begin
                state_q   <= S_DONE;
                res_q     <= w_res_now;
                res_tag_q <= iss_rd_tag;
            end else begin
                state_q   <= S_BUSY;
            end
        end else begin
            case (state_q)
                S_BUSY: begin
                    if (cnt_q <= 4'd1) begin
                        state_q   <= S_DONE;
                        cnt_q     <= '0;
                        res_q     <= w_res_latched;
                        res_tag_q <= op_tag_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    if (cdb_grant) begin
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_exec_unit
// Description : Self-checking bench for mul_exec_unit. Vector table plus
//               hand sequences for CDB stall, back-to-back accept and reset
//               mid-operation; results checked through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_exec_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 6;
    localparam int LAT   = 4;
`ifdef MUL_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             issue_valid;
    logic [XLEN-1:0]  iss_rs1_data;
    logic [XLEN-1:0]  iss_rs2_data;
    logic [TAG_W-1:0] iss_rd_tag;
    logic [1:0]       iss_funct;
    logic             ex_done;
    logic             cdb_req;
    logic             cdb_grant;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_data;
    logic             cdb_data_valid;

    mul_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .LATENCY(LAT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid    (issue_valid),
        .iss_rs1_data   (iss_rs1_data),
        .iss_rs2_data   (iss_rs2_data),
        .iss_rd_tag     (iss_rd_tag),
        .iss_funct      (iss_funct),
        .ex_done        (ex_done),
        .cdb_req        (cdb_req),
        .cdb_grant      (cdb_grant),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .cdb_data_valid (cdb_data_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } res_t;
    res_t sb_q[$];
    res_t mon_e;

    typedef struct {
        logic [1:0]       f;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  exp;
    } vec_t;
    localparam int NV = 11;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference product, written directly with 64-bit signed/unsigned arithmetic
    function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        logic [63:0]     p;
        case (f)
            2'b00:   begin p = ua * ub; return p[31:0]; end
            2'b01:   p = sa * sb;
            2'b10:   p = sa * longint'(ub);
            default: p = ua * ub;
        endcase
        return p[63:32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every CDB publish must match the oldest expected result
    always @(negedge clk) begin
        if (rst_n && cdb_data_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_publish actual tag=0x%0h data=0x%0h required=none", cdb_tag, cdb_data);
            end else begin
                mon_e = sb_q.pop_front();
                check("cdb_tag", 64'(cdb_tag), 64'(mon_e.tag));
                check("cdb_data", 64'(cdb_data), 64'(mon_e.data));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after accept
    task automatic issue_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [5:0] tag, input logic [31:0] exp, output int acc);
        bit got = 1'b0;
        acc          = -1;
        iss_funct    = f;
        iss_rs1_data = a;
        iss_rs2_data = b;
        iss_rd_tag   = tag;
        issue_valid  = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            #1;
            if (ex_done) begin
                got = 1'b1;
                acc = cyc;
                sb_q.push_back('{tag: tag, data: exp});
            end
            tick();
        end
        issue_valid  = 1'b0;
        iss_rs1_data = $urandom;
        iss_rs2_data = $urandom;
        iss_rd_tag   = 6'($urandom);
        iss_funct    = 2'($urandom);
        check("accept_seen", 64'(got), 64'd1);
    endtask

    // Called at posedge+1; returns at posedge+2 of the first DONE cycle
    task automatic wait_req(input int acc, input int lat_exp);
        bit seen = 1'b0;
        int c    = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            #1;
            if (cdb_req) begin
                seen = 1'b1;
                c    = cyc;
            end else begin
                check("no_valid_before_done", 64'(cdb_data_valid), 64'd0);
                tick();
            end
        end
        check("latency", 64'(seen ? (c - acc) : -1), 64'(lat_exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int acc2;
        int lat;
        bit any_req;
        logic [31:0] ra, rb;
        logic [1:0]  rf;

        vecs[0]  = '{2'b00, 32'd7,        32'd6,        6'h2A, 32'd42};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'h01, 32'h00000000};
        vecs[2]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'h02, 32'hFFFFFFFE};
        vecs[3]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'h03, 32'hFFFFFFFF};
        vecs[4]  = '{2'b00, 32'h80000000, 32'd2,        6'h04, 32'h00000000};
        vecs[5]  = '{2'b01, 32'h80000000, 32'h80000000, 6'h05, 32'h40000000};
        vecs[6]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 6'h06, 32'h80000000};
        vecs[7]  = '{2'b11, 32'h12345678, 32'h00000010, 6'h07, 32'h00000001};
        vecs[8]  = '{2'b00, 32'd0,        32'h00001234, 6'h08, 32'h00000000};
        vecs[9]  = '{2'b00, 32'hFFFFFFFF, 32'd3,        6'h09, 32'hFFFFFFFD};
        vecs[10] = '{2'b01, 32'h7FFFFFFF, 32'hFFFFFFFF, 6'h3F, 32'hFFFFFFFF};

        rst_n        = 1'b0;
        issue_valid  = 1'b0;
        iss_rs1_data = '0;
        iss_rs2_data = '0;
        iss_rd_tag   = '0;
        iss_funct    = '0;
        cdb_grant    = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_cdb_req", 64'(cdb_req), 64'd0);
        check("rst_cdb_valid", 64'(cdb_data_valid), 64'd0);
        check("rst_cdb_tag", 64'(cdb_tag), 64'd0);
        check("rst_cdb_data", 64'(cdb_data), 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle_ex_done", 64'(ex_done), 64'd1);

        // Vector table, grant held high
        cdb_grant = 1'b1;
        for (int i = 0; i < NV; i++) begin
            issue_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp, acc);
            lat = (ZS && (vecs[i].a == 0 || vecs[i].b == 0)) ? 1 : LAT;
            wait_req(acc, lat);
            tick();
        end

        // Random operations against the reference model
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            rf = 2'(i);
            issue_op(rf, ra, rb, 6'(i + 16), model(rf, ra, rb), acc);
            wait_req(acc, LAT);
            tick();
        end

        // Grant withheld in DONE, then grant together with a new issue
        cdb_grant = 1'b0;
        issue_op(2'b00, 32'd3, 32'd5, 6'h11, 32'd15, acc);
        wait_req(acc, LAT);
        iss_funct    = 2'b00;
        iss_rs1_data = 32'd100;
        iss_rs2_data = 32'd200;
        iss_rd_tag   = 6'h22;
        issue_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_req", 64'(cdb_req), 64'd1);
            check("stall_ex_done", 64'(ex_done), 64'd0);
            check("stall_valid", 64'(cdb_data_valid), 64'd0);
            check("stall_tag", 64'(cdb_tag), 64'h11);
            check("stall_data", 64'(cdb_data), 64'd15);
            tick();
        end
        cdb_grant = 1'b1;
        #1;
        check("b2b_ex_done", 64'(ex_done), 64'd1);
        check("b2b_valid", 64'(cdb_data_valid), 64'd1);
        sb_q.push_back('{tag: 6'h22, data: 32'd20000});
        acc2 = cyc;
        tick();
        issue_valid = 1'b0;
        wait_req(acc2, LAT);
        tick();

        // Reset asserted while an operation is in BUSY
        issue_op(2'b00, 32'd9, 32'd9, 6'h03, 32'd81, acc);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_cdb_req", 64'(cdb_req), 64'd0);
        check("midrst_ex_done", 64'(ex_done), 64'd1);
        sb_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        any_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (cdb_req) any_req = 1'b1;
            tick();
        end
        check("no_publish_after_reset", 64'(any_req), 64'd0);
        check("post_rst_ex_done", 64'(ex_done), 64'd1);

        // Unit still functional after reset
        issue_op(2'b11, 32'hFFFFFFFF, 32'd2, 6'h15, 32'd1, acc);
        wait_req(acc, LAT);
        tick();
        tick();

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
